// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns: one shared 32-bit column datapath,
// four cycles per state, with an optional pass-through for the final round.
`timescale 1ns/1ps
module mixcolumns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [1:0]   cnt;
    logic [127:0] state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // select the column addressed by the counter
    always_comb begin
        col_in = state_q[127:96];
        unique case (cnt)
            2'd0: col_in = state_q[127:96];
            2'd1: col_in = state_q[95:64];
            2'd2: col_in = state_q[63:32];
            2'd3: col_in = state_q[31:0];
            default: col_in = state_q[127:96];
        endcase
    end

    // the single shared MixColumns column datapath
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        col_out[31:24] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
        col_out[23:16] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
        col_out[15:8]  = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
        col_out[7:0]   = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
    end

    // control FSM with registered handshake outputs; the bypass path
    // spends one staging cycle in DONE before raising out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            cnt         <= 2'd0;
            state_q     <= 128'h0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        state_q    <= data_in;
                        cnt        <= 2'd0;
                        in_ready_q <= 1'b0;
                        fsm        <= bypass ? DONE : CALC;
                    end
                end
                CALC: begin
                    unique case (cnt)
                        2'd0: state_q[127:96] <= col_out;
                        2'd1: state_q[95:64]  <= col_out;
                        2'd2: state_q[63:32]  <= col_out;
                        2'd3: state_q[31:0]   <= col_out;
                        default: state_q[127:96] <= col_out;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        fsm         <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = state_q;

endmodule
